// File: rtl/alu_pkg.sv
// Shared encodings for the ALU sequencing controller: ALU control codes,
// R-type funct values, main-decoder ALU ops and the controller FSM states.
package alu_pkg;

    localparam logic [3:0] ALU_CTL_AND = 4'b0000;
    localparam logic [3:0] ALU_CTL_OR  = 4'b0001;
    localparam logic [3:0] ALU_CTL_ADD = 4'b0010;
    localparam logic [3:0] ALU_CTL_SUB = 4'b0110;
    localparam logic [3:0] ALU_CTL_SLT = 4'b0111;
    localparam logic [3:0] ALU_CTL_NOR = 4'b1100;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_NOR = 6'b100111;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_RTYPE = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } state_t;

endpackage

// File: rtl/alu_seq_ctrl_dec.sv
// alu_ctl_dec: combinational decode of alu_op/funct into the ALU control code,
// a legality flag and an add/sub flag (used to qualify the overflow result).
module alu_ctl_dec
    import alu_pkg::*;
(
    input  logic [1:0] i_alu_op,
    input  logic [5:0] i_funct,
    output logic [3:0] o_ctl,
    output logic       o_legal,
    output logic       o_is_addsub
);

    always_comb begin
        o_ctl       = ALU_CTL_AND;
        o_legal     = 1'b0;
        o_is_addsub = 1'b0;
        case (i_alu_op)
            ALU_OP_ADD: begin
                o_ctl       = ALU_CTL_ADD;
                o_legal     = 1'b1;
                o_is_addsub = 1'b1;
            end
            ALU_OP_SUB: begin
                o_ctl       = ALU_CTL_SUB;
                o_legal     = 1'b1;
                o_is_addsub = 1'b1;
            end
            ALU_OP_RTYPE: begin
                case (i_funct)
                    FUNCT_ADD: begin
                        o_ctl       = ALU_CTL_ADD;
                        o_legal     = 1'b1;
                        o_is_addsub = 1'b1;
                    end
                    FUNCT_SUB: begin
                        o_ctl       = ALU_CTL_SUB;
                        o_legal     = 1'b1;
                        o_is_addsub = 1'b1;
                    end
                    FUNCT_AND: begin
                        o_ctl   = ALU_CTL_AND;
                        o_legal = 1'b1;
                    end
                    FUNCT_OR: begin
                        o_ctl   = ALU_CTL_OR;
                        o_legal = 1'b1;
                    end
                    FUNCT_NOR: begin
                        o_ctl   = ALU_CTL_NOR;
                        o_legal = 1'b1;
                    end
                    FUNCT_SLT: begin
                        o_ctl   = ALU_CTL_SLT;
                        o_legal = 1'b1;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Sequences one operation at a time through an external combinational ALU and
// holds the registered response until consumed. Define ALU_OVF_TRAP_EN for overflow trap + sticky flag.
//
//   state | meaning
//   IDLE  | ready for a request; operands captured on handshake
//   EXEC  | ALU operands driven from registers; result captured at the edge
//   RESP  | response presented and held until rsp_ready
module alu_seq_ctrl
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  alu_op,
    input  logic [5:0]  funct,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_ctl,
    input  logic [31:0] alu_result,
    input  logic        alu_zero,
    input  logic        alu_overflow,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic        rsp_zero,
    output logic        rsp_ovf,
    output logic        rsp_err,
    output logic        rsp_trap,
    output logic        ovf_sticky
);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [3:0]  r_ctl;
    logic        r_legal;
    logic        r_addsub;
    logic [31:0] r_result;
    logic        r_zero;
    logic        r_ovf;
    logic        r_err;
    logic [3:0]  w_ctl;
    logic        w_legal;
    logic        w_addsub;
    logic        w_req_fire;

    alu_ctl_dec u_dec (
        .i_alu_op    (alu_op),
        .i_funct     (funct),
        .o_ctl       (w_ctl),
        .o_legal     (w_legal),
        .o_is_addsub (w_addsub)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        req_ready   = 1'b0;
        rsp_valid   = 1'b0;
        w_req_fire  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_req_fire  = 1'b1;
                    w_state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: w_state_nxt = ST_RESP;
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Illegal ops decode to ALU_CTL_AND (0000), so r_ctl needs no special case.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_ctl    <= ALU_CTL_AND;
            r_legal  <= 1'b0;
            r_addsub <= 1'b0;
            r_result <= '0;
            r_zero   <= 1'b0;
            r_ovf    <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            if (w_req_fire) begin
                r_a      <= src_a;
                r_b      <= src_b;
                r_ctl    <= w_ctl;
                r_legal  <= w_legal;
                r_addsub <= w_addsub;
            end
            if (r_state == ST_EXEC) begin
                r_result <= alu_result;
                r_zero   <= alu_zero;
                r_ovf    <= alu_overflow & r_addsub;
                r_err    <= ~r_legal;
            end
        end
    end

`ifdef ALU_OVF_TRAP_EN
    logic r_trap;
    logic r_sticky;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_trap   <= 1'b0;
            r_sticky <= 1'b0;
        end else if (r_state == ST_EXEC) begin
            r_trap <= alu_overflow & r_addsub;
            if (alu_overflow & r_addsub) begin
                r_sticky <= 1'b1;
            end
        end
    end

    assign rsp_trap   = r_trap;
    assign ovf_sticky = r_sticky;
`else
    assign rsp_trap   = 1'b0;
    assign ovf_sticky = 1'b0;
`endif

    assign alu_a      = r_a;
    assign alu_b      = r_b;
    assign alu_ctl    = r_ctl;
    assign rsp_result = r_result;
    assign rsp_zero   = r_zero;
    assign rsp_ovf    = r_ovf;
    assign rsp_err    = r_err;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Scoreboard bench for alu_seq_ctrl with a behavioural team ALU behind it.
// Directed scenarios first, then randomized traffic with random back-pressure.
module tb_alu_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  alu_op = 2'b00;
    logic [5:0]  funct = 6'b0;
    logic [31:0] src_a = '0;
    logic [31:0] src_b = '0;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_ctl;
    logic [31:0] alu_result;
    logic        alu_zero;
    logic        alu_overflow;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_result;
    logic        rsp_zero;
    logic        rsp_ovf;
    logic        rsp_err;
    logic        rsp_trap;
    logic        ovf_sticky;

    always #5 clk = ~clk;

    alu_seq_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .alu_op       (alu_op),
        .funct        (funct),
        .src_a        (src_a),
        .src_b        (src_b),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_ctl      (alu_ctl),
        .alu_result   (alu_result),
        .alu_zero     (alu_zero),
        .alu_overflow (alu_overflow),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_result   (rsp_result),
        .rsp_zero     (rsp_zero),
        .rsp_ovf      (rsp_ovf),
        .rsp_err      (rsp_err),
        .rsp_trap     (rsp_trap),
        .ovf_sticky   (ovf_sticky)
    );

    // Team ALU: its overflow flag is not qualified by operation, so the
    // controller's masking is exercised on logic ops too.
    always_comb begin
        logic [31:0] sum;
        logic [31:0] dif;
        sum = alu_a + alu_b;
        dif = alu_a - alu_b;
        alu_result   = '0;
        alu_overflow = (alu_a[31] == alu_b[31]) && (sum[31] != alu_a[31]);
        case (alu_ctl)
            4'b0010: alu_result = sum;
            4'b0110: begin
                alu_result   = dif;
                alu_overflow = (alu_a[31] != alu_b[31]) && (dif[31] != alu_a[31]);
            end
            4'b0000: alu_result = alu_a & alu_b;
            4'b0001: alu_result = alu_a | alu_b;
            4'b1100: alu_result = ~(alu_a | alu_b);
            4'b0111: alu_result = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
            default: alu_result = '0;
        endcase
        alu_zero = (alu_result == 32'd0);
    end

    typedef struct {
        logic [31:0] result;
        logic        zero;
        logic        ovf;
        logic        err;
        logic        trap;
        int          due;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail = 0;
    int   cyc = 0;
    bit   model_sticky = 1'b0;
`ifdef ALU_OVF_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Reference: operation semantics from op/funct in plain signed arithmetic.
    function automatic exp_t model(input logic [1:0] op, input logic [5:0] f,
                                   input logic [31:0] a, input logic [31:0] b);
        exp_t   e;
        longint sa;
        longint sb;
        longint s;
        bit     legal;
        bit     addsub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        s = 0;
        legal = 1'b1;
        addsub = 1'b0;
        e.result = a & b;
        if (op == 2'd0) begin
            s = sa + sb; addsub = 1'b1;
        end else if (op == 2'd1) begin
            s = sa - sb; addsub = 1'b1;
        end else if (op == 2'd2) begin
            case (f)
                6'd32: begin s = sa + sb; addsub = 1'b1; end
                6'd34: begin s = sa - sb; addsub = 1'b1; end
                6'd36: e.result = a & b;
                6'd37: e.result = a | b;
                6'd39: e.result = ~(a | b);
                6'd42: e.result = (sa < sb) ? 32'd1 : 32'd0;
                default: legal = 1'b0;
            endcase
        end else begin
            legal = 1'b0;
        end
        e.ovf = 1'b0;
        if (addsub) begin
            e.result = s[31:0];
            e.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        end
        e.zero = (e.result == 32'd0);
        e.err = !legal;
        e.trap = TRAP_EN && e.ovf;
        e.due = 0;
        return e;
    endfunction

    // One driven cycle; a handshake seen before the edge pushes its expectation.
    task automatic drive_cycle(input logic v, input logic rdy, input logic [1:0] op,
                               input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        @(negedge clk);
        req_valid = v;
        rsp_ready = rdy;
        alu_op = op;
        funct = f;
        src_a = a;
        src_b = b;
        #1;
        if (req_valid && req_ready && !rst) begin
            e = model(op, f, a, b);
            e.due = cyc + 2;
            exp_q.push_back(e);
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic [5:0] f,
                         input logic [31:0] a, input logic [31:0] b);
        int t;
        t = 0;
        while (!req_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("issue_wait_timeout", (t >= 50) ? 32'd1 : 32'd0, 32'd0);
        drive_cycle(1'b1, rsp_ready, op, f, a, b);
        drive_cycle(1'b0, rsp_ready, op, f, a, b);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) drive_cycle(1'b0, 1'b1, 2'b00, 6'd0, 32'd0, 32'd0);
    endtask

    // Monitor: compares each presented response against the scoreboard head and
    // checks that a held response stays put while back-pressured.
    initial begin
        exp_t        e;
        bit          prev_valid;
        logic [31:0] h_res;
        logic [4:0]  h_flags;
        prev_valid = 1'b0;
        h_res = '0;
        h_flags = '0;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                prev_valid = 1'b0;
            end else begin
                if (rsp_valid) check("req_ready_in_resp", {31'd0, req_ready}, 32'd0);
                if (rsp_valid && !prev_valid) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_response", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        model_sticky = model_sticky | e.trap;
                        check("latency_cycle", cyc, e.due);
                        check("rsp_result", rsp_result, e.result);
                        check("rsp_zero", {31'd0, rsp_zero}, {31'd0, e.zero});
                        check("rsp_ovf", {31'd0, rsp_ovf}, {31'd0, e.ovf});
                        check("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
                        check("rsp_trap", {31'd0, rsp_trap}, {31'd0, e.trap});
                        check("ovf_sticky", {31'd0, ovf_sticky}, {31'd0, model_sticky});
                    end
                    h_res = rsp_result;
                    h_flags = {rsp_zero, rsp_ovf, rsp_err, rsp_trap, ovf_sticky};
                end else if (rsp_valid && prev_valid) begin
                    check("hold_result", rsp_result, h_res);
                    check("hold_flags", {27'd0, rsp_zero, rsp_ovf, rsp_err, rsp_trap, ovf_sticky},
                          {27'd0, h_flags});
                end
                prev_valid = rsp_valid;
            end
        end
    end

    initial begin
        logic [5:0]  legal_f [6];
        logic [31:0] specials [5];
        logic [1:0]  op;
        logic [5:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        int          t;
        legal_f = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100111, 6'b101010};
        specials = '{32'h7FFFFFFF, 32'h80000000, 32'h0, 32'hFFFFFFFF, 32'h1};

        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("reset_req_ready", {31'd0, req_ready}, 32'd1);
        check("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("reset_rsp_result", rsp_result, 32'd0);
        check("reset_rsp_flags", {27'd0, rsp_zero, rsp_ovf, rsp_err, rsp_trap, ovf_sticky}, 32'd0);
        check("reset_alu_a", alu_a, 32'd0);
        check("reset_alu_b", alu_b, 32'd0);
        check("reset_alu_ctl", {28'd0, alu_ctl}, 32'd0);
        rst = 1'b0;

        // Directed scenarios
        issue(2'b10, 6'b100000, 32'd5, 32'd7);
        check("exec_alu_ctl_add", {28'd0, alu_ctl}, 32'h2);
        idle_cycles(3);
        issue(2'b01, 6'd0, 32'h1234, 32'h1234);
        idle_cycles(3);
        issue(2'b00, 6'd0, 32'h7FFFFFFF, 32'd1);
        idle_cycles(3);
        issue(2'b10, 6'b101010, 32'hFFFFFFFF, 32'd1);
        idle_cycles(3);
        issue(2'b10, 6'b000000, 32'hF0F0F0F0, 32'hFF00FF00);
        check("illegal_alu_ctl", {28'd0, alu_ctl}, 32'h0);
        idle_cycles(3);
        check("illegal_back_to_idle", {31'd0, req_ready}, 32'd1);
        issue(2'b11, 6'b100000, 32'd3, 32'd4);
        idle_cycles(3);

        // Back-pressure with req_valid held, then same-edge retire + new request
        drive_cycle(1'b1, 1'b0, 2'b10, 6'b100010, 32'd100, 32'd58);
        for (int i = 0; i < 7; i++)
            drive_cycle(1'b1, 1'b0, 2'b10, 6'b100101, $urandom, $urandom);
        check("stall_req_ready", {31'd0, req_ready}, 32'd0);
        for (int i = 0; i < 4; i++)
            drive_cycle(1'b1, 1'b1, 2'b00, 6'd0, $urandom, $urandom);
        idle_cycles(4);

        // Reset while in EXEC discards the operation
        issue(2'b00, 6'd0, 32'd9, 32'd9);
        rst = 1'b1;
        exp_q.delete();
        model_sticky = 1'b0;
        @(negedge clk);
        #1;
        check("rst_exec_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_exec_req_ready", {31'd0, req_ready}, 32'd1);
        check("rst_exec_sticky", {31'd0, ovf_sticky}, 32'd0);
        rst = 1'b0;
        idle_cycles(4);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            op = 2'($urandom_range(0, 3));
            f = ($urandom_range(0, 4) != 0) ? legal_f[$urandom_range(0, 5)] : 6'($urandom);
            a = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 4)] : $urandom;
            b = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 4)] : $urandom;
            drive_cycle(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0), op, f, a, b);
        end

        t = 0;
        while (exp_q.size() != 0 && t < 100) begin
            drive_cycle(1'b0, 1'b1, 2'b00, 6'd0, 32'd0, 32'd0);
            t++;
        end
        check("drain_timeout", (t >= 100) ? 32'd1 : 32'd0, 32'd0);
        idle_cycles(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
